// File: rtl/bcd_sseg_pkg.sv
// Shared constants and helpers for the BCD / seven-segment converter.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package bcd_sseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // 1233/4096 approximates log10(2); enough digits for 2^data_w - 1.
    function automatic int int_digits(input int data_w);
        return ((data_w * 1233) >> 12) + 1;
    endfunction

endpackage

// File: rtl/bcd_sseg_converter_enc.sv
// One seven-segment digit: combinational decode with a force-blank override.
// Zero latency, no flow control.
module sseg_digit_enc
    import bcd_sseg_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : seg_encode(digit);

endmodule

// File: rtl/bcd_sseg_converter.sv
// Iterative double-dabble binary-to-BCD converter driving seven-segment digits.
// DATA_W shift cycles plus one DONE cycle; ready only in IDLE, requests elsewhere are dropped.
module bcd_sseg_converter
    import bcd_sseg_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_DIGITS = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_W-1:0]       value_in,
    input  logic                    valid_in,
    input  logic                    blank_en,
    output logic                    ready,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic                    overflow
);

    localparam int INT_DIGITS = int_digits(DATA_W);
    localparam int BCD_W      = INT_DIGITS * 4;
    localparam int SR_W       = BCD_W + DATA_W;
    localparam int PAD_DIGITS = (INT_DIGITS > NUM_DIGITS) ? INT_DIGITS : NUM_DIGITS;
    localparam int PAD_W      = PAD_DIGITS * 4;
    localparam int CNT_W      = $clog2(DATA_W + 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [SR_W-1:0]         sr;
    logic [SR_W-1:0]         sr_adj;
    logic [SR_W-1:0]         sr_shifted;
    logic [CNT_W-1:0]        cnt;
    logic                    blank_lat;
    logic                    accept;
    logic                    finish;
    logic [PAD_W-1:0]        bcd_pad;
    logic [4*NUM_DIGITS-1:0] bcd_nxt;
    logic [4*NUM_DIGITS-1:0] bcd_q;
    logic [NUM_DIGITS-1:0]   mask_nxt;
    logic [NUM_DIGITS-1:0]   mask_q;
    logic                    ovf_nxt;
    logic                    ovf_q;
    logic                    keep;

    assign accept = valid_in && (state == ST_IDLE);
    assign finish = (state == ST_SHIFT) && (cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
            ST_SHIFT: if (finish) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = (state == ST_IDLE);
        done  = (state == ST_DONE);
    end

    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < INT_DIGITS; i++) begin
            if (sr[DATA_W + 4*i +: 4] >= 4'd5)
                sr_adj[DATA_W + 4*i +: 4] = sr[DATA_W + 4*i +: 4] + 4'd3;
        end
    end

    assign sr_shifted = {sr_adj[SR_W-2:0], 1'b0};

    // Results are taken from the post-shift value so they land on the edge entering DONE.
    assign bcd_pad = PAD_W'(sr_shifted[SR_W-1:DATA_W]);
    assign bcd_nxt = bcd_pad[4*NUM_DIGITS-1:0];
    assign ovf_nxt = |(bcd_pad >> (4*NUM_DIGITS));

    always_comb begin
        mask_nxt = '0;
        keep     = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (bcd_nxt[4*i +: 4] != 4'd0) keep = 1'b1;
            mask_nxt[i] = blank_lat && !keep;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr        <= '0;
            cnt       <= '0;
            blank_lat <= 1'b0;
            bcd_q     <= '0;
            mask_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (accept) begin
                sr        <= {{BCD_W{1'b0}}, value_in};
                cnt       <= CNT_W'(DATA_W);
                blank_lat <= blank_en;
            end else if (state == ST_SHIFT) begin
                sr  <= sr_shifted;
                cnt <= cnt - CNT_W'(1);
            end
            if (finish) begin
                bcd_q  <= bcd_nxt;
                mask_q <= mask_nxt;
                ovf_q  <= ovf_nxt;
            end
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        sseg_digit_enc u_enc (
            .digit (bcd_q[4*g +: 4]),
            .blank (mask_q[g]),
            .seg   (hex_out[7*g +: 7])
        );
    end

    assign bcd_out  = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd_sseg_converter.sv
// Bench for bcd_sseg_converter: a 32-bit/6-digit and an 8-bit/3-digit instance.
module tb_bcd_sseg_converter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [31:0] value_a;
    logic        valid_a, blank_a, ready_a, done_a, ovf_a;
    logic [23:0] bcd_a;
    logic [41:0] hex_a;

    logic [7:0]  value_b;
    logic        valid_b, blank_b, ready_b, done_b, ovf_b;
    logic [11:0] bcd_b;
    logic [20:0] hex_b;

    bcd_sseg_converter #(.DATA_W(32), .NUM_DIGITS(6)) dut_a (
        .clk(clk), .reset(reset), .value_in(value_a), .valid_in(valid_a),
        .blank_en(blank_a), .ready(ready_a), .done(done_a), .bcd_out(bcd_a),
        .hex_out(hex_a), .overflow(ovf_a)
    );

    bcd_sseg_converter #(.DATA_W(8), .NUM_DIGITS(3)) dut_b (
        .clk(clk), .reset(reset), .value_in(value_b), .valid_in(valid_b),
        .blank_en(blank_b), .ready(ready_b), .done(done_b), .bcd_out(bcd_b),
        .hex_out(hex_b), .overflow(ovf_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model: plain decimal arithmetic on the value.
    function automatic logic [3:0] mdig(input longint unsigned v, input int i);
        longint unsigned p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        return 4'((v / p) % 10);
    endfunction

    function automatic logic [31:0] m_bcd(input longint unsigned v, input int nd);
        logic [31:0] r = '0;
        for (int i = 0; i < nd; i++) r[4*i +: 4] = mdig(v, i);
        return r;
    endfunction

    function automatic logic m_ovf(input longint unsigned v, input int nd);
        longint unsigned p = 1;
        for (int k = 0; k < nd; k++) p = p * 10;
        return v >= p;
    endfunction

    function automatic logic [55:0] m_hex(input longint unsigned v, input int nd, input logic b);
        logic [6:0]  segs [10];
        logic [55:0] r = '0;
        int          top = 0;
        segs = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        for (int i = 0; i < nd; i++) if (mdig(v, i) != 0) top = i;
        for (int i = 0; i < nd; i++)
            r[7*i +: 7] = (b && i > top) ? 7'h7F : segs[mdig(v, i)];
        return r;
    endfunction

    // Launch one conversion and return cycles from the accept edge to the sampled done.
    task automatic run_a(input logic [31:0] v, input logic b, output int lat);
        @(negedge clk);
        check("a_ready_before", ready_a, 1);
        value_a = v; blank_a = b; valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        lat = 1;
        while (!done_a && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_b(input logic [7:0] v, input logic b, output int lat);
        @(negedge clk);
        check("b_ready_before", ready_b, 1);
        value_b = v; blank_b = b; valid_b = 1'b1;
        @(negedge clk);
        valid_b = 1'b0;
        lat = 1;
        while (!done_b && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [31:0] v;
        logic        b;
        logic [23:0] bcd;
        logic        ovf;
        logic [41:0] hex;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int          lat, n, rdy_hi, dones;
        logic [31:0] v, mb;
        logic [55:0] mh;
        logic        b;

        tbl[0] = '{32'd123456,   1'b0, 24'h123456, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}};
        tbl[1] = '{32'hFFFFFFFF, 1'b0, 24'h967295, 1'b1, {7'h10, 7'h02, 7'h78, 7'h24, 7'h10, 7'h12}};
        tbl[2] = '{32'd1234567,  1'b0, 24'h234567, 1'b1, {7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78}};
        tbl[3] = '{32'd0,        1'b1, 24'h000000, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
        tbl[4] = '{32'd4050,     1'b1, 24'h004050, 1'b0, {7'h7F, 7'h7F, 7'h19, 7'h40, 7'h12, 7'h40}};
        tbl[5] = '{32'd4050,     1'b0, 24'h004050, 1'b0, {7'h40, 7'h40, 7'h19, 7'h40, 7'h12, 7'h40}};
        tbl[6] = '{32'd999999,   1'b1, 24'h999999, 1'b0, {6{7'h10}}};
        tbl[7] = '{32'd1000000,  1'b1, 24'h000000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};

        reset = 1'b1;
        valid_a = 1'b0; value_a = '0; blank_a = 1'b0;
        valid_b = 1'b0; value_b = '0; blank_b = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", ready_a, 1);
        check("rst_done", done_a, 0);
        check("rst_bcd", bcd_a, 0);
        check("rst_ovf", ovf_a, 0);
        check("rst_hex", hex_a, {6{7'h40}});
        check("rst_hex_b", hex_b, {3{7'h40}});

        for (int i = 0; i < 8; i++) begin
            run_a(tbl[i].v, tbl[i].b, lat);
            check($sformatf("tbl%0d_latency", i), lat, 33);
            check($sformatf("tbl%0d_bcd", i), bcd_a, tbl[i].bcd);
            check($sformatf("tbl%0d_ovf", i), ovf_a, tbl[i].ovf);
            check($sformatf("tbl%0d_hex", i), hex_a, tbl[i].hex);
        end

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom;
                1:       v = $urandom_range(0, 9999);
                2:       v = $urandom_range(990000, 1010000);
                default: v = $urandom_range(0, 99) * 10000;
            endcase
            b = 1'($urandom_range(0, 1));
            run_a(v, b, lat);
            mb = m_bcd(v, 6);
            mh = m_hex(v, 6, b);
            check($sformatf("rnd%0d_latency", i), lat, 33);
            check($sformatf("rnd%0d_bcd v=%0d", i, v), bcd_a, mb[23:0]);
            check($sformatf("rnd%0d_ovf v=%0d", i, v), ovf_a, m_ovf(v, 6));
            check($sformatf("rnd%0d_hex v=%0d b=%0d", i, v, b), hex_a, mh[41:0]);
        end

        // valid_in held high: 7 converts, 9 waits until the cycle after DONE.
        @(negedge clk);
        value_a = 32'd7; blank_a = 1'b0; valid_a = 1'b1;
        n = 0; rdy_hi = 0;
        do begin
            @(negedge clk);
            n++;
            if (ready_a) rdy_hi++;
            if (n == 1) value_a = 32'd9;
        end while (!done_a && n < 200);
        check("hold_latency7", n, 33);
        check("hold_bcd7", bcd_a, 24'h7);
        check("hold_ready_low_busy", rdy_hi, 0);
        @(negedge clk);
        check("hold_ready_after_done", ready_a, 1);
        @(negedge clk);
        check("hold_accept9", ready_a, 0);
        valid_a = 1'b0;
        n = 1;
        repeat (10) begin @(negedge clk); n++; end
        check("hold_outputs_stable", bcd_a, 24'h7);
        while (!done_a && n < 200) begin @(negedge clk); n++; end
        check("hold_latency9", n, 33);
        check("hold_bcd9", bcd_a, 24'h9);

        // Reset ten cycles into a conversion.
        @(negedge clk);
        value_a = 32'd123456; valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_ready", ready_a, 1);
        check("midrst_bcd", bcd_a, 0);
        check("midrst_ovf", ovf_a, 0);
        check("midrst_hex", hex_a, {6{7'h40}});
        dones = 0;
        repeat (40) begin @(negedge clk); if (done_a) dones++; end
        check("midrst_no_done", dones, 0);

        // Reset and valid in the same cycle: nothing accepted.
        reset = 1'b1; value_a = 32'd5; valid_a = 1'b1;
        @(negedge clk);
        reset = 1'b0; valid_a = 1'b0;
        check("rst_valid_not_accepted", ready_a, 1);
        @(negedge clk);
        check("rst_valid_still_idle", ready_a, 1);

        run_b(8'd255, 1'b0, lat);
        check("b255_latency", lat, 9);
        check("b255_bcd", bcd_b, 12'h255);
        check("b255_ovf", ovf_b, 0);
        check("b255_hex", hex_b, {7'h24, 7'h12, 7'h12});
        for (int i = 0; i < 8; i++) begin
            v = 32'($urandom_range(0, 255));
            b = 1'($urandom_range(0, 1));
            run_b(v[7:0], b, lat);
            mb = m_bcd(v, 3);
            mh = m_hex(v, 3, b);
            check($sformatf("brnd%0d_latency", i), lat, 9);
            check($sformatf("brnd%0d_bcd v=%0d", i, v), bcd_b, mb[11:0]);
            check($sformatf("brnd%0d_hex v=%0d b=%0d", i, v, b), hex_b, mh[20:0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
